// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline definitions: reset PC, stage payload widths,
// EX/MEM field offsets and the skid-stage state encoding.
package cpu_pipe_pkg;

  localparam logic [31:0] PC_RST = 32'h8000_0000;

  localparam int IF_ID_W  = 64;
  localparam int ID_EX_W  = 152;
  localparam int EX_MEM_W = 120;
  localparam int MEM_WB_W = 109;

  localparam int EXM_RS_LO  = 0;
  localparam int EXM_RS_W   = 15;
  localparam int EXM_ALU_LO = 15;
  localparam int EXM_CAL_LO = 47;
  localparam int EXM_CTL_LO = 48;
  localparam int EXM_INS_LO = 56;
  localparam int EXM_PC_LO  = 88;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [7:0]  ctrl;
    logic        cal_sel;
    logic [31:0] alu_res;
    logic [14:0] rs;
  } ex_mem_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_FULL  = 2'b11
  } skid_st_e;

  function automatic logic [EX_MEM_W-1:0] ex_mem_rst();
    ex_mem_t b;
    b    = '0;
    b.pc = PC_RST;
    return b;
  endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter; holds at all-ones.
// Cleared only by the asynchronous active-low reset.
module pipe_sat_counter
  import cpu_pipe_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  // count qualifying cycles, stop at all-ones
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Registered valid/ready pipeline stage with one-entry skid.
// Optional perf counters: define PIPE_STAGE_PERF_EN.
module pipe_stage_skid
  import cpu_pipe_pkg::*;
#(
  parameter int                DATA_W   = EX_MEM_W,
  parameter logic [DATA_W-1:0] RST_DATA = '0,
  parameter int                CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  skid_st_e          st_q;
  skid_st_e          st_d;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic              accept;
  logic              deliver;
  logic              ld_main;
  logic              ld_skid;
  logic              ld_shift;

  assign accept     = in_valid & in_ready;
  assign deliver    = out_valid & out_ready;
  assign out_valid  = st_q[1];
  assign skid_valid = st_q[0];

  // state and ready flag; ready mirrors next skid emptiness
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q     <= ST_EMPTY;
      in_ready <= 1'b1;
    end else begin
      st_q     <= st_d;
      in_ready <= ~st_d[0];
    end
  end

  // next state and data-load strobes; flush overrides all
  always_comb begin
    st_d     = st_q;
    ld_main  = 1'b0;
    ld_skid  = 1'b0;
    ld_shift = 1'b0;
    if (flush) begin
      st_d = ST_EMPTY;
    end else begin
      case (st_q)
        ST_EMPTY: begin
          if (accept) begin
            ld_main = 1'b1;
            st_d    = ST_ONE;
          end
        end
        ST_ONE: begin
          unique case (1'b1)
            accept & deliver: ld_main = 1'b1;
            accept & ~deliver: begin
              ld_skid = 1'b1;
              st_d    = ST_FULL;
            end
            ~accept & deliver: st_d = ST_EMPTY;
            default: ;
          endcase
        end
        ST_FULL: begin
          if (deliver) begin
            ld_shift = 1'b1;
            st_d     = ST_ONE;
          end
        end
        default: st_d = ST_EMPTY;
      endcase
    end
  end

  // payload registers load only on listed transitions
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data  <= RST_DATA;
      skid_data <= RST_DATA;
    end else begin
      if (ld_main) begin
        out_data <= in_data;
      end else if (ld_shift) begin
        out_data <= skid_data;
      end
      if (ld_skid) begin
        skid_data <= in_data;
      end
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall (
    .clk (clk),
    .rst (rst),
    .inc (out_valid & ~out_ready),
    .cnt (stall_cnt)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_bubble (
    .clk (clk),
    .rst (rst),
    .inc (~out_valid & out_ready),
    .cnt (bubble_cnt)
  );
`else
  logic [CNT_W-1:0] perf_unused;
  assign perf_unused = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed self-checking bench for pipe_stage_skid.
// Perf checks run when PIPE_STAGE_PERF_EN is defined.
module tb_pipe_stage_skid;

  localparam int          DW   = 16;
  localparam int          CW   = 4;
  localparam logic [15:0] RSTV = 16'hBEEF;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] bubble_cnt;
`endif

  int total;
  int bad;

  pipe_stage_skid #(
    .DATA_W   (DW),
    .RST_DATA (RSTV),
    .CNT_W    (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h0011;
    out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_ov", 32'(out_valid), 32'd0);
    chk("rst_ir", 32'(in_ready), 32'd1);
    chk("rst_od", 32'(out_data), 32'(RSTV));

    in_data = 16'h00A5;
    rst     = 1'b1;
    tick();
    chk("a5_ov", 32'(out_valid), 32'd1);
    chk("a5_od", 32'(out_data), 32'h00A5);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("a5_gone", 32'(out_valid), 32'd0);

    for (int i = 1; i <= 8; i++) begin
      push(16'(i));
      chk("str_ov", 32'(out_valid), 32'd1);
      chk("str_od", 32'(out_data), 32'(i));
      chk("str_ir", 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("str_end", 32'(out_valid), 32'd0);

    push(16'd1);
    chk("bp_b1", 32'(out_data), 32'd1);
    out_ready = 1'b0;
    push(16'd2);
    chk("bp_ir0", 32'(in_ready), 32'd0);
    chk("bp_hold1", 32'(out_data), 32'd1);
    push(16'd3);
    chk("bp_ir0b", 32'(in_ready), 32'd0);
    chk("bp_hold1b", 32'(out_data), 32'd1);
    out_ready = 1'b1;
    tick();
    chk("bp_b2", 32'(out_data), 32'd2);
    chk("bp_ir1", 32'(in_ready), 32'd1);
    tick();
    chk("bp_b3", 32'(out_data), 32'd3);
    chk("bp_b3v", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    tick();
    chk("bp_end", 32'(out_valid), 32'd0);

    out_ready = 1'b0;
    push(16'h0040);
    push(16'h0041);
    chk("fl_full", 32'(in_ready), 32'd0);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h0077;
    tick();
    flush = 1'b0;
    chk("fl_ov", 32'(out_valid), 32'd0);
    chk("fl_ir", 32'(in_ready), 32'd1);
    chk("fl_keep", 32'(out_data), 32'h0040);
    in_valid = 1'b0;
    tick();
    chk("fl_no77", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    push(16'h0055);
    chk("fl_next", 32'(out_data), 32'h0055);
    in_valid = 1'b0;
    tick();

    out_ready = 1'b0;
    push(16'h0060);
    push(16'h0061);
    in_valid = 1'b0;
    chk("ar_full", 32'(in_ready), 32'd0);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_ov", 32'(out_valid), 32'd0);
    chk("ar_ir", 32'(in_ready), 32'd1);
    chk("ar_od", 32'(out_data), 32'(RSTV));
    #1;
    rst = 1'b1;
    push(16'h0062);
    chk("ar_first", 32'(out_data), 32'h0062);
    chk("ar_firstv", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    tick();
    chk("ar_drain", 32'(out_valid), 32'd0);

`ifdef PIPE_STAGE_PERF_EN
    out_ready = 1'b0;
    rst       = 1'b0;
    tick();
    rst = 1'b1;
    chk("pf_st0", 32'(stall_cnt), 32'd0);
    chk("pf_bu0", 32'(bubble_cnt), 32'd0);
    push(16'h0001);
    in_valid = 1'b0;
    repeat (5) tick();
    chk("pf_stall5", 32'(stall_cnt), 32'd5);
    out_ready = 1'b1;
    tick();
    chk("pf_bu_pre", 32'(bubble_cnt), 32'd0);
    repeat (20) tick();
    chk("pf_bu_sat", 32'(bubble_cnt), 32'd15);
    chk("pf_st_keep", 32'(stall_cnt), 32'd5);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("pf_fl_keep", 32'(stall_cnt), 32'd5);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
